// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, used by both the display driver and the scan capture monitor.
package seg7_pkg;

  // Active-low segment patterns on seg[6:0] (g..a); a 1 bit means the segment is off.
  localparam logic [6:0] PAT_0    = 7'h40;
  localparam logic [6:0] PAT_1    = 7'h79;
  localparam logic [6:0] PAT_2    = 7'h24;
  localparam logic [6:0] PAT_3    = 7'h30;
  localparam logic [6:0] PAT_4    = 7'h19;
  localparam logic [6:0] PAT_5    = 7'h12;
  localparam logic [6:0] PAT_6    = 7'h02;
  localparam logic [6:0] PAT_7    = 7'h78;
  localparam logic [6:0] PAT_8    = 7'h00;
  localparam logic [6:0] PAT_9    = 7'h10;
  localparam logic [6:0] PAT_A    = 7'h08;
  localparam logic [6:0] PAT_B    = 7'h03;
  localparam logic [6:0] PAT_C    = 7'h46;
  localparam logic [6:0] PAT_D    = 7'h21;
  localparam logic [6:0] PAT_E    = 7'h06;
  localparam logic [6:0] PAT_F    = 7'h0E;
  localparam logic [6:0] PAT_DASH = 7'h3F;

  localparam logic [3:0] DIG0     = 4'b1110;
  localparam logic [3:0] DIG1     = 4'b1101;
  localparam logic [3:0] DIG2     = 4'b1011;
  localparam logic [3:0] DIG3     = 4'b0111;
  localparam logic [3:0] DIG_NONE = 4'b1111;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} cap_state_t;

  typedef struct packed {
    logic [3:0] nibble;
    logic       dash;
    logic       err;
  } seg_dec_t;

  function automatic logic dig_legal(input logic [3:0] d);
    return (d == DIG0) || (d == DIG1) || (d == DIG2) || (d == DIG3);
  endfunction

  function automatic logic [1:0] dig_index(input logic [3:0] d);
    case (d)
      DIG1:    return 2'd1;
      DIG2:    return 2'd2;
      DIG3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse decode of an active-low segment pattern to a hex nibble.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output seg_dec_t   dec
);

  always_comb begin
    dec = '{nibble: 4'h0, dash: 1'b0, err: 1'b0};
    case (pat)
      PAT_0:    dec.nibble = 4'h0;
      PAT_1:    dec.nibble = 4'h1;
      PAT_2:    dec.nibble = 4'h2;
      PAT_3:    dec.nibble = 4'h3;
      PAT_4:    dec.nibble = 4'h4;
      PAT_5:    dec.nibble = 4'h5;
      PAT_6:    dec.nibble = 4'h6;
      PAT_7:    dec.nibble = 4'h7;
      PAT_8:    dec.nibble = 4'h8;
      PAT_9:    dec.nibble = 4'h9;
      PAT_A:    dec.nibble = 4'hA;
      PAT_B:    dec.nibble = 4'hB;
      PAT_C:    dec.nibble = 4'hC;
      PAT_D:    dec.nibble = 4'hD;
      PAT_E:    dec.nibble = 4'hE;
      PAT_F:    dec.nibble = 4'hF;
      PAT_DASH: begin dec.nibble = 4'hF; dec.dash = 1'b1; end
      default:  dec.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed 7-segment bus, captures each settled digit and assembles 4-digit frames.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SCAN_TIMEOUT  = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dig,
  input  logic [7:0]  seg,
  output logic [15:0] digits_o,
  output logic [3:0]  dash_o,
  output logic [3:0]  dp_o,
  output logic        frame_valid_o,
  output logic        frame_err_o,
  output logic        scan_lost_o
);

  localparam logic [7:0]  SET_N = 8'(SETTLE_CYCLES);
  localparam logic [19:0] TMO   = 20'(SCAN_TIMEOUT);

  cap_state_t      state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [3:0]      prev_dig, cap_dig;
  logic [7:0]      prev_seg, cap_seg;
  logic [19:0]     tcnt, tcnt_nxt;
  logic [3:0][3:0] slot_nib;
  logic [3:0]      slot_dash, slot_dp, slot_err, mask;
  logic [1:0]      idx;
  logic            stable, frame_fire;
  seg_dec_t        dec;

  seg7_pattern_decode u_dec (.pat(cap_seg[6:0]), .dec(dec));

  assign stable     = (dig == prev_dig) && (seg == prev_seg);
  assign idx        = dig_index(cap_dig);
  assign frame_fire = (state == CAPTURE) && (idx == 2'd3) && (&mask[2:0]);
  assign tcnt_nxt   = (state == CAPTURE) ? '0 : ((tcnt == TMO) ? tcnt : tcnt + 20'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (dig_legal(dig)) begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
      SETTLE:
        // cnt counts samples already seen stable, so reaching SET_N commits regardless of this sample
        if (cnt == SET_N)         state_nxt = CAPTURE;
        else if (!dig_legal(dig)) state_nxt = IDLE;
        else if (stable)          cnt_nxt   = cnt + 8'd1;
        else                      cnt_nxt   = 8'd1;
      CAPTURE:
        state_nxt = HOLD;
      HOLD:
        if (dig != cap_dig) begin
          if (dig_legal(dig)) begin
            state_nxt = SETTLE;
            cnt_nxt   = 8'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      prev_dig      <= '0;
      prev_seg      <= '0;
      cap_dig       <= '0;
      cap_seg       <= '0;
      tcnt          <= '0;
      slot_nib      <= '0;
      slot_dash     <= '0;
      slot_dp       <= '0;
      slot_err      <= '0;
      mask          <= '0;
      digits_o      <= '0;
      dash_o        <= '0;
      dp_o          <= '0;
      frame_valid_o <= 1'b0;
      frame_err_o   <= 1'b0;
      scan_lost_o   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      prev_dig      <= dig;
      prev_seg      <= seg;
      tcnt          <= tcnt_nxt;
      frame_valid_o <= frame_fire;
      // Latch the settled sample, not the live bus, which may already be moving on
      if (state == SETTLE && cnt == SET_N) begin
        cap_dig <= prev_dig;
        cap_seg <= prev_seg;
      end
      if (state == CAPTURE) begin
        slot_nib[idx]  <= dec.nibble;
        slot_dash[idx] <= dec.dash;
        slot_dp[idx]   <= ~cap_seg[7];
        if (idx == 2'd3) begin
          mask     <= '0;
          slot_err <= '0;
        end else begin
          mask[idx]     <= 1'b1;
          slot_err[idx] <= dec.err;
        end
      end
      if (frame_fire) begin
        digits_o    <= {dec.nibble, slot_nib[2], slot_nib[1], slot_nib[0]};
        dash_o      <= {dec.dash, slot_dash[2:0]};
        dp_o        <= {~cap_seg[7], slot_dp[2:0]};
        frame_err_o <= dec.err | (|slot_err[2:0]);
      end
      if (frame_fire)          scan_lost_o <= 1'b0;
      else if (tcnt_nxt == TMO) scan_lost_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: run-length reference model checked every cycle, directed scans, random scans.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  localparam int S = 8;
  localparam int T = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dig = 4'b0000;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] digits_o;
  logic [3:0]  dash_o, dp_o;
  logic        frame_valid_o, frame_err_o, scan_lost_o;

  always #5 clk = ~clk;

  seg7_scan_capture #(.SETTLE_CYCLES(S), .SCAN_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .dig(dig), .seg(seg),
    .digits_o(digits_o), .dash_o(dash_o), .dp_o(dp_o),
    .frame_valid_o(frame_valid_o), .frame_err_o(frame_err_o), .scan_lost_o(scan_lost_o)
  );

  int total = 0;
  int bad = 0;
  int dut_frames = 0;
  int m_frames = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: run length of identical samples, one capture per digit dwell,
  // a capture lands on the outputs two edges after the run reaches S.
  logic [3:0]  m_prev_dig = 4'hF;
  logic [7:0]  m_prev_seg = 8'h00;
  int          run = 0;
  bit          took = 1'b0;
  bit          p1_v = 1'b0, p2_v = 1'b0;
  logic [3:0]  p1_d = 4'h0, p2_d = 4'h0;
  logic [7:0]  p1_s = 8'h0, p2_s = 8'h0;
  logic [3:0]  nib [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  bit          dsh [4] = '{0, 0, 0, 0};
  bit          dpp [4] = '{0, 0, 0, 0};
  bit          er  [4] = '{0, 0, 0, 0};
  bit          have[4] = '{0, 0, 0, 0};
  int          tsince = 0;
  logic [15:0] e_digits = '0;
  logic [3:0]  e_dash = '0, e_dp = '0;
  logic        e_fv = 1'b0, e_ferr = 1'b0, e_lost = 1'b0;

  function automatic logic [3:0] code_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  function automatic int dig_idx(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (d == code_of(i)) return i;
    return -1;
  endfunction

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] n, output bit ds, output bit e);
    n = 4'h0; ds = 1'b0; e = 1'b1;
    if (p == 7'h3F) begin n = 4'hF; ds = 1'b1; e = 1'b0; end
    for (int i = 0; i < 16; i++) if (tbl[i] == p) begin n = 4'(i); e = 1'b0; end
  endtask

  task automatic model_step();
    logic [3:0] n;
    bit ds, e, fire;
    int k;
    fire = 1'b0;
    if (!rst_n) begin
      m_prev_dig = 4'hF; m_prev_seg = 8'h00; run = 0; took = 1'b0;
      p1_v = 1'b0; p2_v = 1'b0; tsince = 0;
      for (int i = 0; i < 4; i++) begin nib[i] = 4'h0; dsh[i] = 0; dpp[i] = 0; er[i] = 0; have[i] = 0; end
      e_digits = '0; e_dash = '0; e_dp = '0; e_fv = 1'b0; e_ferr = 1'b0; e_lost = 1'b0;
      return;
    end
    if (p2_v) begin
      k = dig_idx(p2_d);
      ref_decode(p2_s[6:0], n, ds, e);
      nib[k] = n; dsh[k] = ds; dpp[k] = ~p2_s[7]; er[k] = e;
      if (k == 3) begin
        if (have[0] && have[1] && have[2]) begin
          fire = 1'b1;
          e_digits = {nib[3], nib[2], nib[1], nib[0]};
          e_dash = {dsh[3], dsh[2], dsh[1], dsh[0]};
          e_dp = {dpp[3], dpp[2], dpp[1], dpp[0]};
          e_ferr = er[0] | er[1] | er[2] | er[3];
          m_frames++;
        end
        for (int i = 0; i < 4; i++) begin have[i] = 0; er[i] = 0; end
      end else begin
        have[k] = 1;
      end
      tsince = 0;
    end else if (tsince < T) begin
      tsince++;
    end
    e_fv = fire;
    if (fire) e_lost = 1'b0;
    else if (tsince == T) e_lost = 1'b1;
    p2_v = p1_v; p2_d = p1_d; p2_s = p1_s; p1_v = 1'b0;
    if (dig_idx(dig) < 0) begin
      run = 0; took = 1'b0;
    end else begin
      if (dig == m_prev_dig && seg == m_prev_seg) run++;
      else begin
        run = 1;
        if (dig != m_prev_dig) took = 1'b0;
      end
      if (run == S && !took) begin p1_v = 1'b1; p1_d = dig; p1_s = seg; took = 1'b1; end
    end
    m_prev_dig = dig; m_prev_seg = seg;
  endtask

  task automatic cycle_compare();
    total++;
    if (frame_valid_o) dut_frames++;
    if ({digits_o, dash_o, dp_o, frame_valid_o, frame_err_o, scan_lost_o} !==
        {e_digits, e_dash, e_dp, e_fv, e_ferr, e_lost}) begin
      bad++;
      if (bad <= 20)
        $display("FAIL cycle t=%0t got dig=%h dash=%b dp=%b fv=%b err=%b lost=%b want dig=%h dash=%b dp=%b fv=%b err=%b lost=%b",
                 $time, digits_o, dash_o, dp_o, frame_valid_o, frame_err_o, scan_lost_o,
                 e_digits, e_dash, e_dp, e_fv, e_ferr, e_lost);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
    dig = d; seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                      input logic [7:0] s3, input int dw);
    drive(DIG0, s0, dw); drive(DIG1, s1, dw); drive(DIG2, s2, dw); drive(DIG3, s3, dw);
  endtask

  initial begin
    int f0, k, r, dw, g;
    logic [3:0] nd, last;
    logic [7:0] s, sg;
    fork
      forever begin
        @(posedge clk);
        model_step();
        #1;
        cycle_compare();
      end
      begin
        repeat (3) @(negedge clk);
        check("reset_digits", 32'(digits_o), 32'h0);
        check("reset_flags", {26'h0, dash_o, frame_valid_o, scan_lost_o}, 32'h0);
        rst_n = 1'b1;

        // dig stuck at 0000
        drive(4'b0000, 8'hFF, T + 5);
        check("lost_set", 32'(scan_lost_o), 32'h1);
        check("stuck_no_frame", 32'(dut_frames), 32'h0);

        f0 = dut_frames;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1000);
        check("scan_frames", 32'(dut_frames - f0), 32'h1);
        check("scan_digits", 32'(digits_o), 32'h3210);
        check("model_digits", 32'(e_digits), 32'h3210);
        check("scan_dash_dp", {24'h0, dash_o, dp_o}, 32'h0);
        check("scan_err_lost", {30'h0, frame_err_o, scan_lost_o}, 32'h0);

        scan(8'h90, 8'h90, 8'h90, 8'hBF, 40);
        check("dash_digits", 32'(digits_o), 32'hF999);
        check("dash_flags", 32'(dash_o), 32'h8);

        // seg glitch restarts settling on digit1
        drive(DIG0, 8'hC0, 40); drive(DIG1, 8'hF9, 5); drive(DIG1, 8'hA4, 35);
        drive(DIG2, 8'hA4, 40); drive(DIG3, 8'hB0, 40);
        check("glitch_digits", 32'(digits_o), 32'h3220);

        // digit1 held one cycle short of settling
        f0 = dut_frames;
        drive(DIG0, 8'hC0, 40); drive(DIG1, 8'hF9, S - 1);
        drive(DIG2, 8'hA4, 40); drive(DIG3, 8'hB0, 40);
        check("short_no_frame", 32'(dut_frames - f0), 32'h0);
        check("short_hold_digits", 32'(digits_o), 32'h3220);

        f0 = dut_frames;
        scan(8'hC0, 8'hF9, 8'hFF, 8'hB0, 40);
        check("err_frames", 32'(dut_frames - f0), 32'h1);
        check("err_flag", 32'(frame_err_o), 32'h1);
        check("err_digits", 32'(digits_o), 32'h3010);
        scan(8'h40, 8'h79, 8'h24, 8'h30, 40);
        check("clean_err_clear", 32'(frame_err_o), 32'h0);
        check("dp_flags", 32'(dp_o), 32'hF);

        // reset after digits 0 and 1 captured
        drive(DIG0, 8'hC0, 40); drive(DIG1, 8'hF9, 40); dig = DIG2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_digits", 32'(digits_o), 32'h0);
        check("midrst_flags", {24'h0, dash_o, dp_o}, 32'h0);
        rst_n = 1'b1;
        f0 = dut_frames;
        scan(8'h90, 8'h90, 8'h90, 8'h90, 40);
        check("post_rst_frames", 32'(dut_frames - f0), 32'h1);
        check("post_rst_digits", 32'(digits_o), 32'h9999);

        // random scans; a legal dwell is either too short to settle or comfortably long
        k = 0; last = DIG3;
        for (int i = 0; i < 400; i++) begin
          r = $urandom_range(0, 99);
          if (r < 8) begin
            case ($urandom_range(0, 3))
              0: nd = 4'b0000;
              1: nd = 4'b1111;
              2: nd = 4'b1010;
              default: nd = 4'b0011;
            endcase
          end else begin
            if (r < 23) k = $urandom_range(0, 3);
            else k = (k + 1) % 4;
            nd = code_of(k);
            if (nd == last) begin k = (k + 1) % 4; nd = code_of(k); end
          end
          if ($urandom_range(0, 99) < 80) begin
            g = $urandom_range(0, 16);
            s = {1'($urandom_range(0, 1)), (g == 16) ? 7'h3F : tbl[g]};
          end else begin
            s = 8'($urandom);
          end
          if ($urandom_range(0, 99) < 15) begin
            drive(nd, s, $urandom_range(1, S - 1));
          end else begin
            dw = $urandom_range(S + 3, S + 25);
            if ($urandom_range(0, 99) < 20) begin
              sg = 8'($urandom);
              drive(nd, sg, $urandom_range(1, 6));
            end
            drive(nd, s, dw);
          end
          last = nd;
        end
        drive(DIG0, 8'hC0, 20);
        check("random_frame_count", 32'(dut_frames), 32'(m_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side monitor for the multiplexed 7-segment bus (active-low one-hot `dig`, active-low `seg`) driven by the board display drivers.
- Tracks the digit scan, waits for each digit's lines to settle, decodes the segment pattern back to a hex nibble and assembles a 4-digit frame.
- Sits beside the display driver for on-chip readback/self-check and as the scoreboard front-end in FFT display benches.

Parameters:
- SETTLE_CYCLES, 8: consecutive cycles (`dig`, `seg`) must be unchanged before a digit is captured; legal range 1..255.
- SCAN_TIMEOUT, 20000: cycles without any capture before `scan_lost_o` asserts; legal range 2..2^20-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- dig  in  4  digit select, active-low one-hot: 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3
- seg  in  8  segment lines, active-low; seg[7]=decimal point, seg[6:0]=g..a
- digits_o  out  16  captured frame, digit0 in [3:0] … digit3 in [15:12]
- dash_o  out  4  per-digit flag: pattern was "-" (nibble stored as 4'hF)
- dp_o  out  4  per-digit decimal point on (captured ~seg[7])
- frame_valid_o  out  1  one-cycle pulse: new frame on digits_o/dash_o/dp_o
- frame_err_o  out  1  qualifies frame_valid_o: at least one digit had an undecodable pattern
- scan_lost_o  out  1  level: no capture for SCAN_TIMEOUT cycles

Behaviour:
- Clock/reset: single clock `clk`; reset `rst_n` is asynchronous and active-low. All outputs reset to 0. FSM resets to IDLE. Capture mask, stability counter and timeout counter reset to 0.
- Decode on seg[6:0] (7-bit hex codes, 1 = segment off):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9
  - 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F
  - 3F→dash: nibble F, dash=1
  - any other code: nibble 0, err flag set for that digit.
- FSM states:
  - IDLE: `dig` not a legal one-hot-low code (includes 0000 and 1111). When `dig` becomes legal → SETTLE, stability counter=1.
  - SETTLE: each cycle, if `dig` and `seg` both equal their previous-cycle values, counter+1; else counter reloads to 1 (if `dig` went illegal → IDLE). When counter reaches SETTLE_CYCLES → CAPTURE.
  - CAPTURE (one cycle): write nibble, dash, dp and err into the slot selected by `dig`; set that mask bit; clear timeout counter → HOLD.
  - HOLD: wait until `dig` differs from the captured code. New legal code → SETTLE (counter=1); illegal code → IDLE. Changes on `seg` alone are ignored in HOLD.
- Frame assembly:
  - Capture of digit3 with mask[2:0]=111: the cycle after CAPTURE, update digits_o/dash_o/dp_o together, pulse frame_valid_o for 1 cycle, and set frame_err_o = OR of the four err flags. Then clear the mask and err flags.
  - Capture of digit3 with an incomplete mask: no frame; clear the mask and err flags.
  - Re-capture of an already-set digit overwrites that slot.
  - frame_err_o holds its value until the next frame.
  - Outputs otherwise hold the last frame.
- Timeout: counter increments every cycle outside CAPTURE and saturates. On reaching SCAN_TIMEOUT, scan_lost_o=1. scan_lost_o clears in the same cycle as the next frame_valid_o pulse.
- Latency: the last digit3 edge plus SETTLE_CYCLES+1 cycles gives CAPTURE; frame_valid_o follows 1 cycle after that.
- Reset mid-frame: the partial mask is discarded and the previous frame outputs go to 0.

Decomposition:
- Shared package `seg7_pkg`: 7-bit pattern constants (PAT_0..PAT_F, PAT_DASH), DIG0..DIG3 select codes, DIG_NONE.
- The display driver uses the same constants.
- One combinational sub-module `seg7_pattern_decode`: seg[6:0] → {nibble[3:0], dash, err}.

Test Plan:
- Scan sequence: hold dig 1110/1101/1011/0111, 1000 cycles each, with seg C0/F9/A4/B0 → one frame_valid_o pulse; digits_o=16'h3210, dash_o=0, dp_o=0, frame_err_o=0.
- Digit3 shows BF, others 90 → digits_o=16'hF999, dash_o=4'b1000, frame_err_o=0.
- Glitch: seg on digit1 toggles F9→A4 at cycle 5 after the dig change, then stays A4 → digit1 captured as 2 (counter restarted). Dig held only SETTLE_CYCLES-1 cycles → that digit not captured, next digit3 produces no frame.
- Digit2 pattern 7F (illegal) → frame_valid_o pulse with frame_err_o=1, digits_o[11:8]=0. The next clean frame clears frame_err_o.
- dig stuck at 0000 from reset for 20000 cycles → scan_lost_o=1, no frames. Normal scan resumes → scan_lost_o=0 on the first frame_valid_o.
- Assert rst_n low after digits 0–1 are captured, then release and give a full scan → all outputs 0 during reset; the first frame contains only post-reset values.
